// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two writeback sources,
// fixed priority to A with a starvation guard that forces a grant to B.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_rd,
    input  logic [31:0]      a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_rd,
    input  logic [31:0]      b_data,
    output logic             RegWrite,
    output logic [4:0]       RD,
    output logic [31:0]      WriteData,
    output logic [CNT_W-1:0] starve_cnt,
    output logic             force_b
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    logic        gnt_a, gnt_b, xfer;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    always_comb begin
        force_b  = starve_cnt == LIMIT;
        gnt_b    = rstn && b_valid && (force_b || !a_valid);
        gnt_a    = rstn && a_valid && !gnt_b;
        xfer     = gnt_a || gnt_b;
        win_rd   = gnt_b ? b_rd : a_rd;
        win_data = gnt_b ? b_data : a_data;
    end
    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    // x0 requests are consumed and latched but never enable the write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RegWrite   <= 1'b0;
            RD         <= '0;
            WriteData  <= '0;
            starve_cnt <= '0;
        end else begin
            RegWrite   <= xfer && win_rd != 5'd0;
            RD         <= xfer ? win_rd : RD;
            WriteData  <= xfer ? win_data : WriteData;
            starve_cnt <= (!b_valid || gnt_b) ? '0 : (force_b ? starve_cnt : starve_cnt + 1'b1);
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: source A (ALU/in-order pipeline writeback) and source B (multi-cycle unit: load/store unit or mul/div).
- Uses a valid/ready handshake per source and fixed priority to A, with a starvation guard that forces a grant to B.
- Drives a registered write command (RegWrite/RD/WriteData) straight into the register file.
- The register file samples on the falling clock edge, so the command is stable for half a cycle before it is written.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles B may be valid-but-denied before B gets forced priority (1..15).
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- a_valid  in  1  source A has a writeback.
- a_ready  out  1  source A accepted this cycle.
- a_rd  in  5  source A destination register.
- a_data  in  32  source A write data.
- b_valid  in  1  source B has a writeback.
- b_ready  out  1  source B accepted this cycle.
- b_rd  in  5  source B destination register.
- b_data  in  32  source B write data.
- RegWrite  out  1  register-file write enable (registered).
- RD  out  5  register-file destination (registered).
- WriteData  out  32  register-file write data (registered).
- starve_cnt  out  CNT_W  current starvation count (debug/visibility).
- force_b  out  1  high when B holds forced priority this cycle.

Behaviour:
- Reset (rstn low, asynchronous): RegWrite=0, RD=0, WriteData=0, starve_cnt=0, force_b=0. a_ready and b_ready are forced to 0 while rstn is low.
- Grant is combinational, one grant per cycle:
  - force_b=0: A wins if a_valid; otherwise B wins if b_valid.
  - force_b=1: B wins if b_valid; otherwise A wins if a_valid.
- a_ready/b_ready equal the grant bits. The arbiter never back-pressures both sources when only one is valid, so a lone request is always accepted the same cycle.
- Handshake: a transfer happens on a rising edge where valid and ready are both high. A source must hold valid/rd/data stable until accepted. The arbiter does not depend on a source withdrawing a request.
- Output register, updated on each rising edge:
  - If a transfer occurred: RD and WriteData take the winner's rd/data. RegWrite=1 when the winner's rd != 0; RegWrite=0 when rd == 0 (the x0 write is dropped but the request is still consumed).
  - If no transfer occurred: RegWrite=0, and RD/WriteData hold their previous values.
- Latency: a request accepted at rising edge N appears on RegWrite/RD/WriteData during cycle N→N+1. The register file writes it at the falling edge inside that cycle. The next reader sees it from rising edge N+1 onward. Throughput is one write per cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each rising edge where b_valid=1 and B is not granted.
  - Clears to 0 on any B transfer, and clears when b_valid=0.
  - force_b = (starve_cnt == STARVE_LIMIT), decoded combinationally from the counter.
- Simultaneous requests to the same rd: the write order equals the grant order. Each is issued in its own cycle, and the later grant overwrites.
- Reset mid-operation: any pending output write is cancelled (RegWrite returns to 0 immediately, asynchronously) and the starvation history is lost. After reset, the sources re-present their requests.
- No internal buffering: exactly one command is in flight, with no queue.

Test Plan:
- Reset and idle:
  - Assert rstn=0 with a_valid=b_valid=1 → a_ready=b_ready=0, RegWrite=0, RD=0, WriteData=0.
  - Release rstn → the first cycle grants A.
- Lone B request: b_valid=1, b_rd=5, b_data=0xDEADBEEF, a_valid=0 → b_ready=1 the same cycle; the next cycle has RegWrite=1, RD=5, WriteData=0xDEADBEEF; the cycle after has RegWrite=0.
- x0 drop: a_valid=1, a_rd=0, a_data=0x12345678 for one cycle → a_ready=1, then RegWrite=0 with RD=0 and WriteData=0x12345678 latched; a register-file read of x0 returns 0.
- Starvation, STARVE_LIMIT=4:
  - Stimulus: a_valid held at 1 continuously; b_valid=1 from cycle 0 with b_rd=7, b_data=0xB.
  - a_ready=1 for cycles 0–3; starve_cnt steps 1,2,3,4.
  - In cycle 4: force_b=1, b_ready=1, a_ready=0.
  - In cycle 5: RegWrite=1, RD=7, WriteData=0xB; starve_cnt=0, and A regains priority.
- Same-rd collision:
  - Stimulus: A (rd=3, data=1) and B (rd=3, data=2) valid together, force_b=0.
  - Two consecutive writes occur: RD=3/1, then RD=3/2; a subsequent read of x3 returns 2.
- Reset mid-stream: pulse rstn=0 asynchronously (between edges) while RegWrite=1 and starve_cnt=3 → RegWrite drops to 0 immediately, starve_cnt=0, and the target register is not written by the falling edge that follows inside the reset pulse.
